// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the RV32I execute stage.
// Holds the ALU opcode, branch-condition and forwarding-select encodings.
package ex_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_NOP   = 4'd15
  } alu_op_e;

  // Encoded exactly as the RISC-V branch funct3 field; 2 and 3 are unused.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_op_e;

  // Code 2'b11 is not listed and falls back to the register file.
  typedef enum logic [1:0] {
    FW_RF  = 2'b00,
    FW_MEM = 2'b01,
    FW_WB  = 2'b10
  } fw_sel_e;

endpackage

// File: rtl/ex_branch_cmp.sv
// ex_branch_cmp: branch condition evaluation, redirect request and target.
// Purely combinational; JALR outranks JAL, which outranks a conditional branch.
module ex_branch_cmp
  import ex_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            valid_i,
  input  logic [2:0]      br_op_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_op_i,
  input  logic [XLEN-1:0] rs2_op_i,
  output logic            flush_o,
  output logic [XLEN-1:0] br_target_o
);

  logic            taken;
  logic [XLEN-1:0] target;

  // Evaluate the branch condition on the forwarded operands.
  always_comb begin
    taken = 1'b0;
    case (br_op_e'(br_op_i))
      BR_BEQ:  taken = (rs1_op_i == rs2_op_i);
      BR_BNE:  taken = (rs1_op_i != rs2_op_i);
      BR_BLT:  taken = ($signed(rs1_op_i) <  $signed(rs2_op_i));
      BR_BGE:  taken = ($signed(rs1_op_i) >= $signed(rs2_op_i));
      BR_BLTU: taken = (rs1_op_i <  rs2_op_i);
      BR_BGEU: taken = (rs1_op_i >= rs2_op_i);
      default: taken = 1'b0;
    endcase
  end

  // Pick the redirect target; JALR clears bit 0 of its computed address.
  always_comb begin
    target = pc_i + imm_i;
    if (is_jalr_i) begin
      target = (rs1_op_i + imm_i) & ~XLEN'(1);
    end
  end

  // Request a redirect only for a valid control-transfer that actually goes.
  always_comb begin
    flush_o     = valid_i & (is_jalr_i | is_jal_i | (is_branch_i & taken));
    br_target_o = flush_o ? target : RESET_PC;
  end

endmodule

// File: rtl/ex_exec_core.sv
// ex_exec_core: RV32I execute stage -- operand forwarding, ALU, branch/jump
// resolution and the EX/MEM result register.
// Optional feature macro EX_BYPASS_EN: when defined, the MEM/WB bypass mux is
// active; otherwise operands always come straight from the register file.
module ex_exec_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [3:0]      alu_op_i,
  input  logic [2:0]      br_op_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic            use_imm_i,
  input  logic            use_pc_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [1:0]      fw_rs1_i,
  input  logic [1:0]      fw_rs2_i,
  input  logic [XLEN-1:0] mem_byp_i,
  input  logic [XLEN-1:0] wb_byp_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  output logic [XLEN-1:0] rd_res_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            valid_o,
  output logic [XLEN-1:0] store_data_o,
  output logic            flush_o,
  output logic [XLEN-1:0] br_target_o
);

  import ex_pkg::*;

  logic [XLEN-1:0] rs1_op;
  logic [XLEN-1:0] rs2_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] ex_res;
  logic            ex_we;
  logic [4:0]      shamt;

`ifdef EX_BYPASS_EN
  // Select each source operand from the RF or one of the two bypass paths.
  always_comb begin
    rs1_op = rs1_data_i;
    rs2_op = rs2_data_i;
    case (fw_sel_e'(fw_rs1_i))
      FW_MEM:  rs1_op = mem_byp_i;
      FW_WB:   rs1_op = wb_byp_i;
      default: rs1_op = rs1_data_i;
    endcase
    case (fw_sel_e'(fw_rs2_i))
      FW_MEM:  rs2_op = mem_byp_i;
      FW_WB:   rs2_op = wb_byp_i;
      default: rs2_op = rs2_data_i;
    endcase
  end
`else
  logic unused_byp;

  // Without bypassing the operands are the register-file values as read.
  always_comb begin
    rs1_op     = rs1_data_i;
    rs2_op     = rs2_data_i;
    unused_byp = ^{fw_rs1_i, fw_rs2_i, mem_byp_i, wb_byp_i};
  end
`endif

  // Steer PC/immediate into the ALU for AUIPC and immediate-form instructions.
  always_comb begin
    op_a  = use_pc_i  ? pc_i  : rs1_op;
    op_b  = use_imm_i ? imm_i : rs2_op;
    shamt = op_b[4:0];
  end

  // Integer ALU; unlisted opcodes produce zero like NOP.
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(alu_op_i))
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  // Jumps write the link address; a plain branch (no jump flag) never writes rd.
  always_comb begin
    ex_res = (is_jal_i | is_jalr_i) ? (pc_i + XLEN'(4)) : alu_res;
    ex_we  = rd_we_i & valid_i & (rd_addr_i != 5'd0)
           & ~(is_branch_i & ~is_jal_i & ~is_jalr_i);
  end

  ex_branch_cmp #(
    .RESET_PC (RESET_PC)
  ) u_branch_cmp (
    .valid_i     (valid_i),
    .br_op_i     (br_op_i),
    .is_branch_i (is_branch_i),
    .is_jal_i    (is_jal_i),
    .is_jalr_i   (is_jalr_i),
    .pc_i        (pc_i),
    .imm_i       (imm_i),
    .rs1_op_i    (rs1_op),
    .rs2_op_i    (rs2_op),
    .flush_o     (flush_o),
    .br_target_o (br_target_o)
  );

  // EX/MEM register: captures every cycle, bubbles only clear the qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_res_o     <= '0;
      rd_addr_o    <= '0;
      rd_we_o      <= 1'b0;
      valid_o      <= 1'b0;
      store_data_o <= '0;
    end else begin
      rd_res_o     <= ex_res;
      rd_addr_o    <= rd_addr_i;
      rd_we_o      <= ex_we;
      valid_o      <= valid_i;
      store_data_o <= rs2_op;
    end
  end

endmodule

// File: tb/tb_ex_exec_core.sv
// tb_ex_exec_core: directed and randomized checks of ex_exec_core against a
// behavioural model of the RV32I execute-stage rules.
module tb_ex_exec_core;

  typedef struct {
    logic        valid;
    logic [3:0]  alu_op;
    logic [2:0]  br_op;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        use_imm;
    logic        use_pc;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  fw1;
    logic [1:0]  fw2;
    logic [31:0] mem;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        we;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [3:0]  alu_op_i;
  logic [2:0]  br_op_i;
  logic        is_branch_i;
  logic        is_jal_i;
  logic        is_jalr_i;
  logic        use_imm_i;
  logic        use_pc_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [1:0]  fw_rs1_i;
  logic [1:0]  fw_rs2_i;
  logic [31:0] mem_byp_i;
  logic [31:0] wb_byp_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic [31:0] rd_res_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        valid_o;
  logic [31:0] store_data_o;
  logic        flush_o;
  logic [31:0] br_target_o;

  int n_cmp = 0;
  int n_err = 0;

  ex_exec_core #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .alu_op_i     (alu_op_i),
    .br_op_i      (br_op_i),
    .is_branch_i  (is_branch_i),
    .is_jal_i     (is_jal_i),
    .is_jalr_i    (is_jalr_i),
    .use_imm_i    (use_imm_i),
    .use_pc_i     (use_pc_i),
    .pc_i         (pc_i),
    .imm_i        (imm_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .fw_rs1_i     (fw_rs1_i),
    .fw_rs2_i     (fw_rs2_i),
    .mem_byp_i    (mem_byp_i),
    .wb_byp_i     (wb_byp_i),
    .rd_addr_i    (rd_addr_i),
    .rd_we_i      (rd_we_i),
    .rd_res_o     (rd_res_o),
    .rd_addr_o    (rd_addr_o),
    .rd_we_o      (rd_we_o),
    .valid_o      (valid_o),
    .store_data_o (store_data_o),
    .flush_o      (flush_o),
    .br_target_o  (br_target_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------

  function automatic logic [31:0] operand(input logic [1:0] fw, input logic [31:0] rf,
                                          input logic [31:0] mem, input logic [31:0] wb);
`ifdef EX_BYPASS_EN
    if (fw == 2'd1) return mem;
    if (fw == 2'd2) return wb;
`endif
    return rf;
  endfunction

  function automatic longint to_signed(input logic [31:0] v);
    longint r;
    r = longint'(v);
    if (v >= 32'h8000_0000) r = r - 64'sh1_0000_0000;
    return r;
  endfunction

  function automatic logic [31:0] model_alu(input txn_t t);
    logic [31:0] a, b;
    longint      sa, sb, d, q;
    int          sh;
    a  = t.use_pc  ? t.pc  : operand(t.fw1, t.rs1, t.mem, t.wb);
    b  = t.use_imm ? t.imm : operand(t.fw2, t.rs2, t.mem, t.wb);
    sa = to_signed(a);
    sb = to_signed(b);
    sh = int'(b % 32);
    d  = longint'(1) << sh;
    case (t.alu_op)
      4'd0:  return 32'(longint'(a) + longint'(b));
      4'd1:  return 32'(longint'(a) - longint'(b));
      4'd2:  return 32'(longint'(a) * d);
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return 32'(longint'(a) / d);
      4'd7: begin
        if (sa >= 0) q = sa / d;
        else         q = -((-sa + d - 1) / d);
        return 32'(q);
      end
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(input txn_t t);
    logic [31:0] a, b;
    a = operand(t.fw1, t.rs1, t.mem, t.wb);
    b = operand(t.fw2, t.rs2, t.mem, t.wb);
    case (t.br_op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return to_signed(a) <  to_signed(b);
      3'd5: return to_signed(a) >= to_signed(b);
      3'd6: return longint'(a) <  longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_flush(input txn_t t);
    return t.valid & (t.is_jal | t.is_jalr | (t.is_branch & model_taken(t)));
  endfunction

  function automatic logic [31:0] model_target(input txn_t t);
    logic [31:0] a;
    if (!model_flush(t)) return 32'h0;
    a = operand(t.fw1, t.rs1, t.mem, t.wb);
    if (t.is_jalr) return 32'(longint'(a) + longint'(t.imm)) & 32'hFFFF_FFFE;
    return 32'(longint'(t.pc) + longint'(t.imm));
  endfunction

  function automatic logic [31:0] model_res(input txn_t t);
    if (t.is_jal || t.is_jalr) return 32'(longint'(t.pc) + 4);
    return model_alu(t);
  endfunction

  function automatic logic model_we(input txn_t t);
    logic plain_branch;
    plain_branch = t.is_branch && !t.is_jal && !t.is_jalr;
    return t.we && t.valid && (t.rd != 5'd0) && !plain_branch;
  endfunction

  function automatic txn_t blank();
    txn_t t;
    t = '{valid: 1'b1, alu_op: 4'd15, br_op: 3'd0, is_branch: 1'b0, is_jal: 1'b0,
          is_jalr: 1'b0, use_imm: 1'b0, use_pc: 1'b0, pc: 32'h0, imm: 32'h0,
          rs1: 32'h0, rs2: 32'h0, fw1: 2'd0, fw2: 2'd0, mem: 32'h0, wb: 32'h0,
          rd: 5'd1, we: 1'b1};
    return t;
  endfunction

  // ---------------- checking / stimulus ----------------

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input txn_t t);
    valid_i     = t.valid;
    alu_op_i    = t.alu_op;
    br_op_i     = t.br_op;
    is_branch_i = t.is_branch;
    is_jal_i    = t.is_jal;
    is_jalr_i   = t.is_jalr;
    use_imm_i   = t.use_imm;
    use_pc_i    = t.use_pc;
    pc_i        = t.pc;
    imm_i       = t.imm;
    rs1_data_i  = t.rs1;
    rs2_data_i  = t.rs2;
    fw_rs1_i    = t.fw1;
    fw_rs2_i    = t.fw2;
    mem_byp_i   = t.mem;
    wb_byp_i    = t.wb;
    rd_addr_i   = t.rd;
    rd_we_i     = t.we;
  endtask

  task automatic checkRegs(input string tag, input txn_t t);
    checkOutput({tag, "_res"},   rd_res_o,            model_res(t));
    checkOutput({tag, "_addr"},  32'(rd_addr_o),      32'(t.rd));
    checkOutput({tag, "_we"},    32'(rd_we_o),        32'(model_we(t)));
    checkOutput({tag, "_valid"}, 32'(valid_o),        32'(t.valid));
    checkOutput({tag, "_store"}, store_data_o,        operand(t.fw2, t.rs2, t.mem, t.wb));
  endtask

  // Called just after a rising edge: drive, check the combinational redirect,
  // then check the registered result after the next edge.
  task automatic applyStimulus(input string tag, input txn_t t);
    drive(t);
    #1;
    checkOutput({tag, "_flush"},  32'(flush_o), 32'(model_flush(t)));
    checkOutput({tag, "_target"}, br_target_o,  model_target(t));
    @(posedge clk);
    #1;
    checkRegs(tag, t);
  endtask

  txn_t t;
  logic [31:0] exp_fw;

  initial begin
    rst = 1'b1;
    t = blank();
    t.valid = 1'b0;
    drive(t);
    #3;
    checkOutput("rst_res",   rd_res_o,           32'h0);
    checkOutput("rst_we",    32'(rd_we_o),       32'h0);
    checkOutput("rst_valid", 32'(valid_o),       32'h0);
    checkOutput("rst_addr",  32'(rd_addr_o),     32'h0);
    checkOutput("rst_store", store_data_o,       32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD / SUB
    t = blank(); t.alu_op = 4'd0; t.rs1 = 32'd7; t.rs2 = 32'd5; t.rd = 5'd3;
    applyStimulus("add", t);
    checkOutput("add_const", rd_res_o, 32'd12);
    checkOutput("add_we_const", 32'(rd_we_o), 32'd1);
    t.alu_op = 4'd1; t.rs1 = 32'd5; t.rs2 = 32'd7;
    applyStimulus("sub", t);
    checkOutput("sub_const", rd_res_o, 32'hFFFF_FFFE);

    // Shifts with immediate
    t = blank(); t.alu_op = 4'd7; t.rs1 = 32'h8000_0000; t.imm = 32'd4; t.use_imm = 1'b1;
    applyStimulus("sra", t);
    checkOutput("sra_const", rd_res_o, 32'hF800_0000);
    t.alu_op = 4'd6;
    applyStimulus("srl", t);
    checkOutput("srl_const", rd_res_o, 32'h0800_0000);

    // Forwarding
`ifdef EX_BYPASS_EN
    exp_fw = 32'd101;
`else
    exp_fw = 32'd2;
`endif
    t = blank(); t.alu_op = 4'd0; t.rs1 = 32'd1; t.rs2 = 32'd1;
    t.mem = 32'd100; t.wb = 32'd200; t.fw1 = 2'd1;
    applyStimulus("fw_mem", t);
    checkOutput("fw_mem_const", rd_res_o, exp_fw);
`ifdef EX_BYPASS_EN
    exp_fw = 32'd201;
`endif
    t.fw1 = 2'd2;
    applyStimulus("fw_wb", t);
    checkOutput("fw_wb_const", rd_res_o, exp_fw);
    t.fw1 = 2'd3;
    applyStimulus("fw_11", t);
    checkOutput("fw_11_const", rd_res_o, 32'd2);

    // Signed vs unsigned branch
    t = blank(); t.is_branch = 1'b1; t.br_op = 3'd4; t.pc = 32'h100; t.imm = 32'h20;
    t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'd1; t.rd = 5'd0; t.we = 1'b0;
    drive(t);
    #1;
    checkOutput("blt_flush_const",  32'(flush_o), 32'd1);
    checkOutput("blt_target_const", br_target_o,  32'h120);
    @(posedge clk);
    #1;
    checkOutput("blt_we_const", 32'(rd_we_o), 32'd0);
    t.br_op = 3'd6; t.rd = 5'd4; t.we = 1'b1;
    applyStimulus("bltu", t);
    checkOutput("bltu_flush_const", 32'(flush_o), 32'd0);

    // JALR
    t = blank(); t.is_jalr = 1'b1; t.pc = 32'h200; t.rs1 = 32'h301; t.imm = 32'd4; t.rd = 5'd1;
    drive(t);
    #1;
    checkOutput("jalr_target_const", br_target_o,  32'h304);
    checkOutput("jalr_flush_const",  32'(flush_o), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("jalr_res_const", rd_res_o, 32'h204);

    // Mid-stream reset after a valid ADD; redirect stays combinational
    t = blank(); t.alu_op = 4'd0; t.rs1 = 32'd9; t.rs2 = 32'd9; t.rd = 5'd7;
    applyStimulus("pre_rst", t);
    t = blank(); t.is_jal = 1'b1; t.pc = 32'h40; t.imm = 32'h10; t.rd = 5'd2;
    drive(t);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_res",    rd_res_o,       32'h0);
    checkOutput("mid_rst_we",     32'(rd_we_o),   32'h0);
    checkOutput("mid_rst_valid",  32'(valid_o),   32'h0);
    checkOutput("mid_rst_addr",   32'(rd_addr_o), 32'h0);
    checkOutput("mid_rst_store",  store_data_o,   32'h0);
    checkOutput("mid_rst_flush",  32'(flush_o),   32'd1);
    checkOutput("mid_rst_target", br_target_o,    32'h50);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkRegs("post_rst", t);

    // Bubble carrying a JAL flag
    t.valid = 1'b0;
    applyStimulus("bubble_jal", t);
    checkOutput("bubble_flush_const", 32'(flush_o), 32'd0);
    checkOutput("bubble_valid_const", 32'(valid_o), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      t = blank();
      t.valid   = ($urandom_range(0, 9) != 0);
      t.alu_op  = 4'($urandom_range(0, 15));
      t.br_op   = 3'($urandom_range(0, 7));
      t.use_imm = 1'($urandom_range(0, 1));
      t.use_pc  = ($urandom_range(0, 4) == 0);
      t.pc      = $urandom() & 32'hFFFF_FFFC;
      t.imm     = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 64));
      t.rs1     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      t.rs2     = ($urandom_range(0, 3) == 0) ? t.rs1 : $urandom();
      t.fw1     = 2'($urandom_range(0, 3));
      t.fw2     = 2'($urandom_range(0, 3));
      t.mem     = $urandom();
      t.wb      = $urandom();
      t.rd      = 5'($urandom_range(0, 31));
      t.we      = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel <= 3) t.is_branch = 1'b1;
      else if (sel == 4) t.is_jal = 1'b1;
      else if (sel == 5) t.is_jalr = 1'b1;
      else if (sel == 6) begin
        t.is_branch = 1'($urandom_range(0, 1));
        t.is_jal    = 1'($urandom_range(0, 1));
        t.is_jalr   = 1'($urandom_range(0, 1));
      end
      applyStimulus("rnd", t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
